// File: rtl/bcd_sseg_scan_pkg.sv
// Package: bcd_sseg_scan_pkg
// Shared seven-segment definitions for the display blocks.
// Segment order is {g,f,e,d,c,b,a}, active-low (0 = segment lit).
// SEG_0..SEG_9 are the decimal glyphs, SEG_DASH marks an illegal BCD nibble,
// and SEG_BLANK turns every segment off.
package bcd_sseg_scan_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_sseg.sv
// Module: bcd_to_sseg
// Combinational BCD digit to active-low seven-segment decoder.
// Ports:
//   bcd  in  4  BCD digit; values A..F are not valid BCD and decode to a dash
//   seg  out 7  {g,f,e,d,c,b,a}, active-low
module bcd_to_sseg
    import bcd_sseg_scan_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_sseg_scan.sv
// Module: bcd_sseg_scan
// Captures a packed BCD word on a valid strobe and time-multiplexes its digits
// onto a common-anode seven-segment display (active-low anodes, segments, dp).
// Contains the refresh divider, digit scan counter, per-digit decode and
// registered outputs.
// Parameters:
//   NUM_DIGITS   number of digits; bcd_in digit 0 is bits [3:0]
//   REFRESH_DIV  clk cycles per digit slot (>= 2)
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   bcd_in     in   packed BCD digits
//   bcd_valid  in   load bcd_in/dp_in into the shadow registers this cycle
//   dp_in      in   decimal point per digit, 1 = lit
//   an         out  anode enables, active-low, one-hot-low while scanning
//   seg        out  {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal point, active-low
// Build option:
//   LEAD_ZERO_BLANK_EN  when defined, leading zero digits (idx > 0) are dark
//                       for their slot; digit 0 is always shown.
module bcd_sseg_scan
    import bcd_sseg_scan_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic                      bcd_valid,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp
);

    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [DIV_W-1:0]                div_cnt_reg;
    logic [IDX_W-1:0]                idx_reg;
    logic [NUM_DIGITS-1:0][3:0]      shadow_bcd_reg;
    logic [NUM_DIGITS-1:0]           shadow_dp_reg;

    logic [6:0]                      digit_seg [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]           digit_blank;
    logic                            div_wrap;

    assign div_wrap = (div_cnt_reg == DIV_W'(REFRESH_DIV - 1));

    // Refresh divider and scan index: idx steps once per full divider period.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_reg <= '0;
            idx_reg     <= '0;
        end else begin
            if (div_wrap) begin
                div_cnt_reg <= '0;
                if (idx_reg == IDX_W'(NUM_DIGITS - 1)) begin
                    idx_reg <= '0;
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end else begin
                div_cnt_reg <= div_cnt_reg + 1'b1;
            end
        end
    end

    // Shadow registers hold the displayed value between valid strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_bcd_reg <= '0;
            shadow_dp_reg  <= '0;
        end else if (bcd_valid) begin
            shadow_bcd_reg <= bcd_in;
            shadow_dp_reg  <= dp_in;
        end
    end

    // One decoder per digit; the output stage just selects the active one.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
            bcd_to_sseg u_dec (
                .bcd (shadow_bcd_reg[gi]),
                .seg (digit_seg[gi])
            );
        end
    endgenerate

`ifdef LEAD_ZERO_BLANK_EN
    // A digit is a leading zero when it and every higher digit are zero.
    // Walk from the most significant digit down, accumulating the all-zero flag.
    logic upper_zero;
    always_comb begin
        digit_blank = '0;
        upper_zero  = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            upper_zero     = upper_zero && (shadow_bcd_reg[i] == 4'd0);
            digit_blank[i] = upper_zero;
        end
    end
`else
    assign digit_blank = '0;
`endif

    // Registered outputs. They use the idx/shadow values from before this
    // edge, so a capture is visible one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else if (digit_blank[idx_reg]) begin
            an  <= '1;
            seg <= SEG_BLANK;
            dp  <= 1'b1;
        end else begin
            an  <= ~(NUM_DIGITS'(1) << idx_reg);
            seg <= digit_seg[idx_reg];
            dp  <= ~shadow_dp_reg[idx_reg];
        end
    end

endmodule

// File: tb/tb_bcd_sseg_scan.sv
// Testbench for bcd_sseg_scan (NUM_DIGITS=2, REFRESH_DIV=4).
// A reference model tracks time since reset and the last captured word, and
// derives the expected anode/segment/dp pattern every cycle; a compare process
// checks the DUT on each falling edge. A few literal expectations pin the model.
module tb_bcd_sseg_scan;

    localparam int ND  = 2;
    localparam int DIV = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [4*ND-1:0] bcd_in = '0;
    logic            bcd_valid = 1'b0;
    logic [ND-1:0]   dp_in = '0;
    logic [ND-1:0]   an;
    logic [6:0]      seg;
    logic            dp;

    int vectors = 0;
    int errors  = 0;

    bcd_sseg_scan #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .bcd_in    (bcd_in),
        .bcd_valid (bcd_valid),
        .dp_in     (dp_in),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    always #5 clk = ~clk;

    // Glyph table indexed by nibble value.
    logic [6:0] glyph [16];
    initial begin
        glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100;
        glyph[3] = 7'b0110000; glyph[4] = 7'b0011001; glyph[5] = 7'b0010010;
        glyph[6] = 7'b0000010; glyph[7] = 7'b1111000; glyph[8] = 7'b0000000;
        glyph[9] = 7'b0010000;
        for (int i = 10; i < 16; i++) glyph[i] = 7'b0111111;
    end

    // Reference model
    int          cycles_since_rst = 0;
    int          digit_val [ND];
    bit          digit_dp  [ND];
    bit          model_live = 0;
    logic [ND-1:0] exp_an;
    logic [6:0]    exp_seg;
    logic          exp_dp;

    always @(posedge clk) begin
        int  slot;
        bit  blank;
        if (rst) begin
            exp_an  = '1;
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
            cycles_since_rst = 0;
            for (int i = 0; i < ND; i++) begin
                digit_val[i] = 0;
                digit_dp[i]  = 0;
            end
            model_live = 1;
        end else begin
            slot  = (cycles_since_rst / DIV) % ND;
            blank = 0;
`ifdef LEAD_ZERO_BLANK_EN
            if (slot > 0) begin
                blank = 1;
                for (int j = slot; j < ND; j++)
                    if (digit_val[j] != 0) blank = 0;
            end
`endif
            if (blank) begin
                exp_an  = '1;
                exp_seg = 7'h7F;
                exp_dp  = 1'b1;
            end else begin
                exp_an  = '1;
                exp_an[slot] = 1'b0;
                exp_seg = glyph[digit_val[slot]];
                exp_dp  = !digit_dp[slot];
            end
            cycles_since_rst++;
            if (bcd_valid) begin
                for (int i = 0; i < ND; i++) begin
                    digit_val[i] = int'(bcd_in[4*i +: 4]);
                    digit_dp[i]  = dp_in[i];
                end
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (model_live) begin
            vectors++;
            if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
                errors++;
                $display("FAIL model t=%0t an=%b seg=%b dp=%b required an=%b seg=%b dp=%b",
                         $time, an, seg, dp, exp_an, exp_seg, exp_dp);
            end
        end
    end

    task automatic check_lit(input string name, input logic [ND-1:0] a_exp,
                             input logic [6:0] s_exp);
        vectors++;
        if (an !== a_exp || seg !== s_exp) begin
            errors++;
            $display("FAIL %s an=%b seg=%b required an=%b seg=%b", name, an, seg, a_exp, s_exp);
        end else begin
            $display("ok   %s an=%b seg=%b", name, an, seg);
        end
    endtask

    task automatic load(input logic [4*ND-1:0] v, input logic [ND-1:0] d);
        @(negedge clk);
        #1;
        bcd_in = v; dp_in = d; bcd_valid = 1'b1;
        @(negedge clk);
        #1;
        bcd_valid = 1'b0;
    endtask

    // Wait (bounded) for a given anode pattern, sampling at falling edges.
    task automatic wait_an(input logic [ND-1:0] a, input string name, output bit found);
        found = 0;
        for (int i = 0; i < 4 * DIV * ND; i++) begin
            @(negedge clk);
            #1;
            if (an === a) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            vectors++;
            errors++;
            $display("FAIL %s timeout waiting for an=%b, last an=%b", name, a, an);
        end
    endtask

    function automatic logic [3:0] rand_nib();
        int r;
        r = $urandom_range(0, 15);
        if (r >= 10 && $urandom_range(0, 3) != 0) r = r % 10;
        return 4'(r);
    endfunction

    initial begin
        bit found;
        // Reset for 3 cycles
        repeat (3) @(negedge clk);
        #1;
        check_lit("reset_dark", 2'b11, 7'h7F);
        vectors++;
        if (dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_dp dp=%b required 1", dp);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_lit("first_edge", 2'b10, 7'b1000000);

        // 8'h32: digit0 = 2, digit1 = 3
        load(8'h32, 2'b00);
        wait_an(2'b01, "h32_d1", found);
        if (found) check_lit("h32_d1", 2'b01, 7'b0110000);
        wait_an(2'b10, "h32_d0", found);
        if (found) check_lit("h32_d0", 2'b10, 7'b0100100);

        // 8'h16 with dp on digit 1 (checked by the model)
        load(8'h16, 2'b10);
        repeat (3 * DIV) @(negedge clk);

        // 8'h0A: digit0 illegal -> dash
        load(8'h0A, 2'b00);
        wait_an(2'b10, "h0A_d0", found);
        if (found) check_lit("h0A_d0", 2'b10, 7'b0111111);
        repeat (2 * DIV) @(negedge clk);

        // Reset in the middle of a digit-1 slot
        load(8'h45, 2'b01);
        wait_an(2'b01, "mid_rst", found);
        #1 rst = 1'b1;
        @(negedge clk);
        #1;
        check_lit("mid_rst_dark", 2'b11, 7'h7F);
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_lit("restart", 2'b10, 7'b1000000);

        // Randomized traffic, occasional resets
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            #1;
            rst       = ($urandom_range(0, 99) == 0);
            bcd_valid = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 3))
                0: bcd_in = {4'd0, rand_nib()};
                1: bcd_in = 8'h00;
                2: bcd_in = 8'h99;
                default: bcd_in = {rand_nib(), rand_nib()};
            endcase
            dp_in = 2'($urandom_range(0, 3));
        end
        @(negedge clk);
        #1;
        rst = 1'b0; bcd_valid = 1'b0;
        repeat (2 * DIV * ND) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
